mole_button_conditioner: RTL and testbench

- Front end for the mole-panel push-buttons; the game core consumes its output instead of sampling raw pins.
- Synchronizes and debounces N active-low buttons, then produces clean levels and one-cycle press/release pulses.
- Queues presses as button-ID events over a valid/ready handshake, so simultaneous hits are never merged.
- Flags presses that are lost because an identical event is already pending.

---
 rtl/mole_button_conditioner.sv | 67 ++++++
 tb/tb_mole_button_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mole_button_conditioner.sv
// mole_button_conditioner: synchronize, debounce and queue active-low mole-panel buttons
//   clk, reset (async, active-high); btn_n raw active-low buttons; enable gates pulses/events
//   level debounced state; press/rel one-cycle press/release pulses
//   ev_valid/ev_id/ev_ready press-event handshake; ovf sticky dropped-press flag, ovf_clr clears it
module mole_button_conditioner #(
  parameter int N_BTN = 5,
  parameter int ID_W = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             enable,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic             ev_valid,
  output logic [ID_W-1:0]  ev_id,
  input  logic             ev_ready,
  output logic             ovf,
  input  logic             ovf_clr
);
  localparam logic [CNT_W-1:0] cnt_last = CNT_W'(DEBOUNCE_CYCLES);
  logic [N_BTN-1:0] s1, s2, s, toggle, pending, pending_nxt, take, drop;
  logic [ID_W-1:0] first_id;
  logic gap;
  assign s = ~s2;
  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    assign toggle[i] = (s[i] != level[i]) && (cnt == cnt_last);
    always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (s[i] == level[i] || toggle[i]) ? '0 : cnt + 1'b1;
  end
  assign ev_valid = |pending && !gap;
  always_comb begin
    take = '0;
    for (int i = 0; i < N_BTN; i++) take[i] = ev_valid && ev_ready && ev_id == ID_W'(i);
    drop = enable ? press & pending & ~take : '0;
    pending_nxt = enable ? (pending & ~take) | press : '0;
    first_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) if (pending_nxt[i]) first_id = ID_W'(i);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      level <= '0;
      press <= '0;
      rel <= '0;
      pending <= '0;
      gap <= 1'b0;
      ev_id <= '0;
      ovf <= 1'b0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      level <= level ^ toggle;
      press <= enable ? toggle & ~level : '0;
      rel <= enable ? toggle & level : '0;
      pending <= pending_nxt;
      gap <= ev_valid && ev_ready;
      ev_id <= (ev_valid && !ev_ready) ? ev_id : first_id;
      ovf <= |drop || (ovf && !ovf_clr);
    end
endmodule

// File: tb/tb_mole_button_conditioner.sv
// tb_mole_button_conditioner: scoreboard bench for the button conditioner with a short debounce
module tb_mole_button_conditioner;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, ev_ready = 1'b0, ovf_clr = 1'b0;
  logic [4:0] btn_n = '1, level, press, rel, press_seen, rel_seen;
  logic ev_valid, ovf;
  logic [2:0] ev_id;
  int vectors = 0, miscompares = 0;
  int q[$];
  always #5 clk = ~clk;
  mole_button_conditioner #(.N_BTN(5), .ID_W(3), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .enable(enable), .level(level), .press(press),
    .rel(rel), .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      press_seen = press_seen | press;
      rel_seen = rel_seen | rel;
      if (ev_valid && ev_ready) begin
        if (q.size() == 0) check("event_expected", q.size(), 1);
        else check("ev_id", ev_id, q.pop_front());
      end
    end
  initial begin
    press_seen = '0;
    rel_seen = '0;
    tick(2);
    check("rst_level", level, 0);
    check("rst_press", press, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_id", ev_id, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;
    btn_n[1] = 1'b0;
    tick(6);
    check("t1_level_early", level, 0);
    tick(1);
    check("t1_level", level, 5'b00010);
    check("t1_press", press, 5'b00010);
    q.push_back(1);
    tick(1);
    check("t1_press_gone", press, 0);
    check("t1_valid", ev_valid, 1);
    check("t1_id", ev_id, 1);
    repeat (5) begin
      tick(1);
      check("t1_hold_valid", ev_valid, 1);
      check("t1_hold_id", ev_id, 1);
    end
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check("t1_valid_drop", ev_valid, 0);
    btn_n[1] = 1'b1;
    tick(7);
    check("t1_release", rel, 5'b00010);
    check("t1_level_off", level, 0);
    tick(1);
    ev_ready = 1'b1;
    press_seen = '0;
    rel_seen = '0;
    repeat (10) begin
      btn_n[2] = 1'b0;
      tick(3);
      btn_n[2] = 1'b1;
      tick(3);
    end
    check("t2_glitch_level", level, 0);
    check("t2_glitch_press", press_seen, 0);
    q.push_back(2);
    btn_n[2] = 1'b0;
    tick(6);
    btn_n[2] = 1'b1;
    tick(10);
    check("t2_press_seen", press_seen, 5'b00100);
    check("t2_rel_seen", rel_seen, 5'b00100);
    check("t2_level", level, 0);
    q.push_back(0);
    q.push_back(3);
    btn_n[0] = 1'b0;
    btn_n[3] = 1'b0;
    tick(7);
    check("t3_press", press, 5'b01001);
    tick(1);
    check("t3_valid0", ev_valid, 1);
    check("t3_id0", ev_id, 0);
    tick(1);
    check("t3_gap", ev_valid, 0);
    tick(1);
    check("t3_valid3", ev_valid, 1);
    check("t3_id3", ev_id, 3);
    tick(1);
    check("t3_idle", ev_valid, 0);
    check("t3_ovf", ovf, 0);
    btn_n = '1;
    tick(8);
    check("t3_queue", q.size(), 0);
    ev_ready = 1'b0;
    q.push_back(4);
    btn_n[4] = 1'b0;
    tick(8);
    check("t4_valid", ev_valid, 1);
    check("t4_id", ev_id, 4);
    btn_n[4] = 1'b1;
    tick(8);
    btn_n[4] = 1'b0;
    tick(7);
    check("t4_ovf_before", ovf, 0);
    tick(1);
    check("t4_ovf_set", ovf, 1);
    check("t4_id_held", ev_id, 4);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf, 0);
    btn_n[4] = 1'b1;
    tick(8);
    btn_n[4] = 1'b0;
    tick(7);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr2", ovf, 0);
    ev_ready = 1'b1;
    tick(2);
    check("t4_single_event", ev_valid, 0);
    check("t4_queue", q.size(), 0);
    btn_n[4] = 1'b1;
    tick(8);
    press_seen = '0;
    enable = 1'b0;
    btn_n[3] = 1'b0;
    tick(7);
    check("t5_level", level, 5'b01000);
    check("t5_press_off", press, 0);
    tick(1);
    check("t5_no_valid", ev_valid, 0);
    enable = 1'b1;
    tick(5);
    check("t5_reenable_valid", ev_valid, 0);
    check("t5_reenable_press", press_seen, 0);
    btn_n[3] = 1'b1;
    tick(8);
    check("t5_level_off", level, 0);
    ev_ready = 1'b0;
    q.push_back(3);
    btn_n[3] = 1'b0;
    tick(8);
    check("t5_valid", ev_valid, 1);
    check("t5_id", ev_id, 3);
    enable = 1'b0;
    tick(1);
    check("t5_disable_flush", ev_valid, 0);
    void'(q.pop_front());
    enable = 1'b1;
    tick(2);
    check("t5_stay_flushed", ev_valid, 0);
    btn_n[3] = 1'b1;
    tick(8);
    btn_n[1] = 1'b0;
    tick(8);
    check("t6_valid", ev_valid, 1);
    btn_n[2] = 1'b0;
    tick(4);
    #2 reset = 1'b1;
    #1;
    check("t6_level", level, 0);
    check("t6_press", press, 0);
    check("t6_valid", ev_valid, 0);
    check("t6_id", ev_id, 0);
    check("t6_ovf", ovf, 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("t6_level_early", level, 0);
    tick(1);
    check("t6_level_back", level, 5'b00110);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
